dev_bridge: RTL

DEV_BRIDGE -- requirements
Module: dev_bridge

---
 rtl/dev_bridge_pkg.sv | 52 +++++
 rtl/dev_bridge_irq_sync_edge.sv | 52 +++++
 rtl/dev_bridge.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dev_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dev_bridge_pkg
//  Purpose  : Shared bus definitions for the device bridge. Holds the default
//             window bases and sizes, the full-word byte-enable constant, the
//             hwint bit positions, the device-select encoding and a helper
//             that decides whether a word address falls inside a window.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dev_bridge_pkg;

    // Default device windows (byte addresses, word aligned)
    localparam logic [31:0] c_tc0_base  = 32'h0000_7F00;
    localparam logic [31:0] c_tc1_base  = 32'h0000_7F10;
    localparam logic [31:0] c_intc_base = 32'h0000_7F20;

    // Window sizes in 32-bit words
    localparam int unsigned c_tc_words   = 3;
    localparam int unsigned c_intc_words = 1;

    // Byte-enable pattern of a full-word store
    localparam logic [3:0] c_full_word = 4'b1111;

    // Pending / hwint bit positions
    localparam int c_hwint_tc0 = 0;
    localparam int c_hwint_tc1 = 1;
    localparam int c_hwint_ext = 2;
    localparam int c_pend_w    = 3;
    localparam int c_hwint_w   = 6;

    // Which device the current M-stage address selects
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_TC0  = 2'd1,
        SEL_TC1  = 2'd2,
        SEL_INTC = 2'd3
    } dev_sel_e;

    // True when word address lies in [base, base + words). The subtraction
    // wraps modulo 2^30, so addresses below the base land far above the
    // window and are rejected by the same single compare.
    function automatic logic win_hit(input logic [29:0] word_addr,
                                     input logic [29:0] word_base,
                                     input int unsigned words);
        logic [29:0] off;
        off = word_addr - word_base;
        return ({2'b00, off} < words);
    endfunction

endpackage : dev_bridge_pkg
`default_nettype wire

// File: rtl/dev_bridge_irq_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : irq_sync_edge
//  Purpose  : Brings an asynchronous interrupt level into the clk domain
//             through a STAGES-deep flop chain and flags 0->1 transitions of
//             the synchronized level as a one-cycle combinational pulse.
//  Ports    : clk   - clock
//             RESET - synchronous active-high reset
//             din   - asynchronous level input
//             rise  - high for one cycle when the synchronized level rises
//  Revision : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
    parameter int STAGES = 2            // legal range 2..3
) (
    input  logic clk,
    input  logic RESET,
    input  logic din,
    output logic rise
);

    // The chain and history restart at zero, so a level already high at
    // reset release would look like a fresh edge. Edges are suppressed until
    // every sync stage and the history flop hold real post-reset samples.
    localparam int c_fill   = STAGES + 1;
    localparam int c_fill_w = $clog2(c_fill + 1);

    logic [STAGES-1:0]   r_sync;
    logic                r_prev;
    logic [c_fill_w-1:0] r_fill;
    logic                w_armed;

    assign w_armed = (r_fill == c_fill_w'(c_fill));

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], din};
            r_prev <= r_sync[STAGES-1];
            if (!w_armed) begin
                r_fill <= r_fill + c_fill_w'(1);
            end
        end
    end

    assign rise = w_armed & r_sync[STAGES-1] & ~r_prev;

endmodule : irq_sync_edge
`default_nettype wire

// File: rtl/dev_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : dev_bridge
//  Purpose  : Memory-mapped bridge between the CPU M-stage bus and two timers
//             plus a small interrupt-status word. Decodes device windows,
//             forwards full-word stores, drops partial stores with an error
//             flag, returns registered load data and latches interrupt edges
//             into write-1-to-clear pending bits driving hwint.
//  Ports    : clk, RESET                 - clock, synchronous active-high reset
//             cpu_addr/wdata/byteen      - M-stage request
//             cpu_rdata                  - registered load data (next cycle)
//             dev_hit                    - address hits a mapped word
//             acc_err                    - previous-cycle store was dropped
//             tc0_*/tc1_*                - timer ports
//             ext_irq                    - asynchronous external interrupt
//             hwint                      - {3'b000, pending[2:0]} to CP0
//  Revision : 1.0 - initial release
// ============================================================================
module dev_bridge
    import dev_bridge_pkg::*;
#(
    parameter logic [31:0] TC0_BASE    = c_tc0_base,
    parameter logic [31:0] TC1_BASE    = c_tc1_base,
    parameter logic [31:0] INTC_BASE   = c_intc_base,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    input  logic [3:0]           cpu_byteen,
    output logic [31:0]          cpu_rdata,
    output logic                 dev_hit,
    output logic                 acc_err,
    output logic [31:0]          tc0_addr,
    output logic [31:0]          tc0_wdata,
    output logic [3:0]           tc0_byteen,
    input  logic [31:0]          tc0_rdata,
    input  logic                 tc0_irq,
    output logic [31:0]          tc1_addr,
    output logic [31:0]          tc1_wdata,
    output logic [3:0]           tc1_byteen,
    input  logic [31:0]          tc1_rdata,
    input  logic                 tc1_irq,
    input  logic                 ext_irq,
    output logic [c_hwint_w-1:0] hwint
);

    dev_sel_e              w_sel;
    logic                  w_full;
    logic                  w_drop;
    logic [31:0]           w_rdata_n;
    logic                  w_ext_rise;
    logic [c_pend_w-1:0]   w_rise;
    logic [c_pend_w-1:0]   w_clr;
    logic [c_pend_w-1:0]   w_pend_n;

    logic [31:0]           r_rdata;
    logic                  r_acc_err;
    logic [1:0]            r_tc_prev;     // {tc1, tc0} levels from last cycle
    logic                  r_armed;       // tc history holds a real sample
    logic [c_pend_w-1:0]   r_pend;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    always_comb begin
        w_sel = SEL_NONE;
        if (win_hit(cpu_addr[31:2], TC0_BASE[31:2], c_tc_words)) begin
            w_sel = SEL_TC0;
        end else if (win_hit(cpu_addr[31:2], TC1_BASE[31:2], c_tc_words)) begin
            w_sel = SEL_TC1;
        end else if (win_hit(cpu_addr[31:2], INTC_BASE[31:2], c_intc_words)) begin
            w_sel = SEL_INTC;
        end
    end

    assign dev_hit = (w_sel != SEL_NONE);
    assign w_full  = (cpu_byteen == c_full_word);
    assign w_drop  = dev_hit && (cpu_byteen != 4'b0000) && !w_full;

    // ------------------------------------------------------------------
    // Timer forwarding: address and data pass straight through; only a
    // full-word store to the addressed timer gets its byte enables. This
    // path is purely combinational and so keeps working during RESET.
    // ------------------------------------------------------------------
    assign tc0_addr   = cpu_addr;
    assign tc1_addr   = cpu_addr;
    assign tc0_wdata  = cpu_wdata;
    assign tc1_wdata  = cpu_wdata;
    assign tc0_byteen = (w_sel == SEL_TC0 && w_full) ? c_full_word : 4'b0000;
    assign tc1_byteen = (w_sel == SEL_TC1 && w_full) ? c_full_word : 4'b0000;

    // ------------------------------------------------------------------
    // Load data mux, registered below
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata_n = 32'h0000_0000;
        case (w_sel)
            SEL_TC0:  w_rdata_n = tc0_rdata;
            SEL_TC1:  w_rdata_n = tc1_rdata;
            SEL_INTC: w_rdata_n = {{(32 - c_pend_w){1'b0}}, r_pend};
            default:  w_rdata_n = 32'h0000_0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Interrupt edges. Timer levels are already synchronous; the external
    // level goes through the synchronizer first.
    // ------------------------------------------------------------------
    irq_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_ext_sync (
        .clk   (clk),
        .RESET (RESET),
        .din   (ext_irq),
        .rise  (w_ext_rise)
    );

    always_comb begin
        w_rise              = '0;
        w_rise[c_hwint_tc0] = r_armed & tc0_irq & ~r_tc_prev[0];
        w_rise[c_hwint_tc1] = r_armed & tc1_irq & ~r_tc_prev[1];
        w_rise[c_hwint_ext] = w_ext_rise;
    end

    // Write-1-to-clear on a full-word store to the status word; a new edge
    // in the same cycle takes priority over the clear.
    assign w_clr    = (w_sel == SEL_INTC && w_full) ? cpu_wdata[c_pend_w-1:0] : '0;
    assign w_pend_n = (r_pend & ~w_clr) | w_rise;

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_rdata   <= 32'h0000_0000;
            r_acc_err <= 1'b0;
            r_tc_prev <= 2'b00;
            r_armed   <= 1'b0;
            r_pend    <= '0;
        end else begin
            r_rdata   <= w_rdata_n;
            r_acc_err <= w_drop;
            r_tc_prev <= {tc1_irq, tc0_irq};
            r_armed   <= 1'b1;
            r_pend    <= w_pend_n;
        end
    end

    assign cpu_rdata = r_rdata;
    assign acc_err   = r_acc_err;
    assign hwint     = {{(c_hwint_w - c_pend_w){1'b0}}, r_pend};

endmodule : dev_bridge
`default_nettype wire
